// File: rtl/pcpi_ser_pkg.sv
// Shared types and constants for the PCPI result serializer.
package pcpi_ser_pkg;

  localparam int NIBBLES_PER_WORD = 8;
  localparam int IDX_W            = $clog2(NIBBLES_PER_WORD);
  localparam int WORD_W           = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESENT  = 2'd1,
    ST_WAIT_LOW = 2'd2
  } ser_state_e;

endpackage

// File: rtl/result_fifo.sv
// Small circular result buffer. A push while full is accepted only when a
// pop happens in the same cycle; otherwise it is silently refused here and
// the caller decides what that means.
module result_fifo
  import pcpi_ser_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^n.
  always_comb begin
    wr_en    = push && (!full || pop);
    rd_en    = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pcpi_result_serializer.sv
// Buffers PCPI write-back results and hands them to a host one nibble at a
// time over a 4-phase handshake on an asynchronous acknowledge pin.
module pcpi_result_serializer
  import pcpi_ser_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pcpi_ready,
  input  logic              pcpi_wr,
  input  logic [WORD_W-1:0] pcpi_rd,
  input  logic              host_ack,
  input  logic              ovf_clr,
  output logic [3:0]        nib_out,
  output logic              nib_valid,
  output logic              nib_last,
  output logic              buf_full,
  output logic              ovf
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES_PER_WORD - 1);

  ser_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   ovf_q, ovf_d;
  logic                   ack_s;
  logic                   push_req;
  logic                   pop;
  logic                   drop;
  logic                   full;
  logic                   empty;
  logic [WORD_W-1:0]      head;

  assign push_req = pcpi_ready && pcpi_wr;
  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign drop     = push_req && full && !pop;

  result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req),
    .pop     (pop),
    .wr_data (pcpi_rd),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  // Acknowledge synchronizer shift and sticky overflow (a drop beats a clear).
  always_comb begin
    ack_sync_d[0] = host_ack;
    for (int i = 1; i < SYNC_STAGES; i++) ack_sync_d[i] = ack_sync_q[i-1];
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Handshake FSM: present a nibble, wait for ack high, then for ack low.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (ack_s) begin
          state_d = ST_WAIT_LOW;
          if (idx_q == LAST_IDX) begin
            pop   = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_WAIT_LOW: begin
        if (!ack_s) begin
          state_d = (idx_q != '0 || !empty || push_req) ? ST_PRESENT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ack_sync_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ack_sync_q <= ack_sync_d;
      ovf_q      <= ovf_d;
    end
  end

  // The head word cannot change while PRESENT, so nib_out is stable; it is
  // gated so that the unreset buffer contents never reach the pins.
  assign nib_valid = (state_q == ST_PRESENT);
  assign nib_last  = nib_valid && (idx_q == LAST_IDX);
  assign nib_out   = nib_valid ? head[{idx_q, 2'b00} +: 4] : 4'h0;
  assign buf_full  = full;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pcpi_result_serializer.sv
// Directed self-checking bench for pcpi_result_serializer (DEPTH=2).
module tb_pcpi_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        host_ack;
  logic        ovf_clr;
  logic [3:0]  nib_out;
  logic        nib_valid;
  logic        nib_last;
  logic        buf_full;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  pcpi_result_serializer #(
    .DEPTH       (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcpi_ready (pcpi_ready),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .host_ack   (host_ack),
    .ovf_clr    (ovf_clr),
    .nib_out    (nib_out),
    .nib_valid  (nib_valid),
    .nib_last   (nib_last),
    .buf_full   (buf_full),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] d, input logic wr);
    pcpi_ready = 1'b1;
    pcpi_wr    = wr;
    pcpi_rd    = d;
    step();
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
  endtask

  // Host side of one 4-phase handshake; reports the nibble and whether it held.
  task automatic handshake_one(output logic [3:0] nib, output logic last,
                               output bit ok, output bit stable);
    bit found;
    ok = 1'b0; stable = 1'b1; nib = 4'h0; last = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (nib_valid === 1'b1) found = 1'b1;
      else step();
    end
    if (!found) return;
    nib = nib_out;
    last = nib_last;
    host_ack = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (nib_valid === 1'b0) found = 1'b1;
      else if (nib_out !== nib) stable = 1'b0;
    end
    host_ack = 1'b0;
    ok = found;
  endtask

  task automatic recv_word(output logic [31:0] w, output logic [7:0] lm,
                           output bit ok, output bit stable);
    logic [3:0] n;
    logic       l;
    bit         o, s;
    w = 32'h0; lm = 8'h0; ok = 1'b1; stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      handshake_one(n, l, o, s);
      w[4*i +: 4] = n;
      lm[i] = l;
      ok = ok & o;
      stable = stable & s;
      if (!o) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if (nib_out !== 4'h0) begin failures++; $display("FAIL rst_nib_out got=%h exp=0", nib_out); end
    checks++; if (nib_valid !== 1'b0) begin failures++; $display("FAIL rst_nib_valid got=%b exp=0", nib_valid); end
    checks++; if (nib_last !== 1'b0) begin failures++; $display("FAIL rst_nib_last got=%b exp=0", nib_last); end
    checks++; if (buf_full !== 1'b0) begin failures++; $display("FAIL rst_buf_full got=%b exp=0", buf_full); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_single_word();
    logic [31:0] w; logic [7:0] lm; bit ok, st;
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h8765_4321;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    checks++; if (nib_valid !== 1'b0) begin failures++; $display("FAIL lat_edge1_valid got=%b exp=0", nib_valid); end
    step();
    checks++; if (nib_valid !== 1'b1) begin failures++; $display("FAIL lat_edge2_valid got=%b exp=1", nib_valid); end
    checks++; if (nib_out !== 4'h1) begin failures++; $display("FAIL first_nibble got=%h exp=1", nib_out); end
    checks++; if (nib_last !== 1'b0) begin failures++; $display("FAIL first_not_last got=%b exp=0", nib_last); end
    recv_word(w, lm, ok, st);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_timeout got=%b exp=1", ok); end
    checks++; if (w !== 32'h8765_4321) begin failures++; $display("FAIL single_word got=%h exp=87654321", w); end
    checks++; if (lm !== 8'h80) begin failures++; $display("FAIL single_last_mask got=%h exp=80", lm); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL single_stable got=%b exp=1", st); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w; logic [7:0] lm; bit ok, st;
    drive_push(32'hAAAA_0001, 1'b1);
    drive_push(32'hBBBB_0002, 1'b1);
    checks++; if (buf_full !== 1'b1) begin failures++; $display("FAIL b2b_full got=%b exp=1", buf_full); end
    recv_word(w, lm, ok, st);
    checks++; if (w !== 32'hAAAA_0001 || !ok) begin failures++; $display("FAIL b2b_word0 got=%h exp=aaaa0001", w); end
    checks++; if (lm !== 8'h80) begin failures++; $display("FAIL b2b_last0 got=%h exp=80", lm); end
    recv_word(w, lm, ok, st);
    checks++; if (w !== 32'hBBBB_0002 || !ok) begin failures++; $display("FAIL b2b_word1 got=%h exp=bbbb0002", w); end
    repeat (6) step();
    checks++; if (buf_full !== 1'b0) begin failures++; $display("FAIL b2b_drained_full got=%b exp=0", buf_full); end
    checks++; if (nib_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_valid got=%b exp=0", nib_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] w; logic [7:0] lm; bit ok, st, seen;
    drive_push(32'h1357_9BDF, 1'b1);
    drive_push(32'h0246_8ACE, 1'b1);
    drive_push(32'hFFFF_EEEE, 1'b1);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    checks++; if (buf_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", buf_full); end
    ovf_clr = 1'b1;
    drive_push(32'hDEAD_DEAD, 1'b1);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", ovf); end
    step();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
    recv_word(w, lm, ok, st);
    checks++; if (w !== 32'h1357_9BDF || !ok) begin failures++; $display("FAIL ovf_word0 got=%h exp=13579bdf", w); end
    recv_word(w, lm, ok, st);
    checks++; if (w !== 32'h0246_8ACE || !ok) begin failures++; $display("FAIL ovf_word1 got=%h exp=02468ace", w); end
    seen = 1'b0;
    repeat (30) begin step(); if (nib_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL ovf_dropped_presented got=%b exp=0", seen); end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] w; logic [7:0] lm; bit ok, st, found;
    logic [3:0] n; logic l; bit o, s;
    drive_push(32'h0F1E_2D3C, 1'b1);
    drive_push(32'h4B5A_6978, 1'b1);
    checks++; if (buf_full !== 1'b1) begin failures++; $display("FAIL fpp_full got=%b exp=1", buf_full); end
    for (int i = 0; i < 7; i++) handshake_one(n, l, o, s);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (nib_valid === 1'b1) found = 1'b1;
      else step();
    end
    checks++; if (nib_last !== 1'b1 || nib_out !== 4'h0) begin failures++; $display("FAIL fpp_last_nib got=%b/%h exp=1/0", nib_last, nib_out); end
    host_ack = 1'b1;
    step(); step();
    checks++; if (nib_valid !== 1'b1) begin failures++; $display("FAIL fpp_prepop_valid got=%b exp=1", nib_valid); end
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hCAFE_F00D;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    host_ack = 1'b0;
    checks++; if (nib_valid !== 1'b0) begin failures++; $display("FAIL fpp_popped_valid got=%b exp=0", nib_valid); end
    checks++; if (buf_full !== 1'b1) begin failures++; $display("FAIL fpp_still_full got=%b exp=1", buf_full); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fpp_no_ovf got=%b exp=0", ovf); end
    recv_word(w, lm, ok, st);
    checks++; if (w !== 32'h4B5A_6978 || !ok) begin failures++; $display("FAIL fpp_word1 got=%h exp=4b5a6978", w); end
    recv_word(w, lm, ok, st);
    checks++; if (w !== 32'hCAFE_F00D || !ok) begin failures++; $display("FAIL fpp_word2 got=%h exp=cafef00d", w); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fpp_ovf_end got=%b exp=0", ovf); end
  endtask

  task automatic test_no_write();
    bit seen;
    drive_push(32'h1234_5678, 1'b0);
    seen = 1'b0;
    repeat (30) begin step(); if (nib_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL nowr_presented got=%b exp=0", seen); end
    checks++; if (buf_full !== 1'b0) begin failures++; $display("FAIL nowr_full got=%b exp=0", buf_full); end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w; logic [7:0] lm; bit ok, st, found, seen;
    logic [3:0] n; logic l; bit o, s;
    drive_push(32'h7654_3210, 1'b1);
    drive_push(32'h5555_AAAA, 1'b1);
    drive_push(32'h3333_3333, 1'b1);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL rmw_pre_ovf got=%b exp=1", ovf); end
    for (int i = 0; i < 3; i++) handshake_one(n, l, o, s);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (nib_valid === 1'b1) found = 1'b1;
      else step();
    end
    checks++; if (nib_out !== 4'h3 || nib_valid !== 1'b1) begin failures++; $display("FAIL rmw_fourth_nib got=%h/%b exp=3/1", nib_out, nib_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (nib_valid !== 1'b0) begin failures++; $display("FAIL rmw_async_valid got=%b exp=0", nib_valid); end
    checks++; if (nib_out !== 4'h0) begin failures++; $display("FAIL rmw_async_nib got=%h exp=0", nib_out); end
    checks++; if (buf_full !== 1'b0) begin failures++; $display("FAIL rmw_async_full got=%b exp=0", buf_full); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rmw_async_ovf got=%b exp=0", ovf); end
    checks++; if (nib_last !== 1'b0) begin failures++; $display("FAIL rmw_async_last got=%b exp=0", nib_last); end
    step(); step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin step(); if (nib_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rmw_post_presented got=%b exp=0", seen); end
    checks++; if (buf_full !== 1'b0) begin failures++; $display("FAIL rmw_post_full got=%b exp=0", buf_full); end
    drive_push(32'h9ABC_DEF0, 1'b1);
    recv_word(w, lm, ok, st);
    checks++; if (w !== 32'h9ABC_DEF0 || !ok) begin failures++; $display("FAIL rmw_fresh_word got=%h exp=9abcdef0", w); end
    checks++; if (lm !== 8'h80) begin failures++; $display("FAIL rmw_fresh_last got=%h exp=80", lm); end
  endtask

  initial begin
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'h0;
    host_ack   = 1'b0;
    ovf_clr    = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_full_pop_push();
    test_no_write();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
